// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler and its raster counter.
package hdmi_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL     = 2'd0,
        MODE_PREAMBLE = 2'd1,
        MODE_GUARD    = 2'd2,
        MODE_VIDEO    = 2'd3
    } tmds_mode_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } sched_state_t;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned PX_W         = 24;
    localparam int unsigned BAR_CNT      = 8;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [7:0] BAR_LVL            = 8'hC0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to per-channel index bits.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = idx[1] ? 8'h00 : BAR_LVL;
        c.g = idx[2] ? 8'h00 : BAR_LVL;
        c.b = idx[0] ? 8'h00 : BAR_LVL;
        return c;
    endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Free-running h/v raster counters with raw region flags decoded from the current count.
module hdmi_timing_cnt #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    output logic [HW-1:0] h_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          next_line_active,
    output logic          frame_start
);

    logic [VW-1:0] v_cnt;

    // v advances on the h wrap; both wrap together on the last clock of the frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_comb begin
        active           = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hsync            = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                           (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
        vsync            = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                           (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
        next_line_active = (v_cnt == VW'(V_TOTAL - 1)) || (v_cnt < VW'(V_ACTIVE - 1));
        frame_start      = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/hdmi_period_sched.sv
// HDMI TX period scheduler: raster timing, period selection and frame lock to the pixel stream.
// Optional `HDMI_SCHED_PATTERN_EN: colour bars replace black video while unlocked.
module hdmi_period_sched
    import hdmi_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [PX_W-1:0] px_data_i,
    input  logic            px_valid_i,
    input  logic            px_sof_i,
    output logic            px_ready_o,
    output logic [PX_W-1:0] enc_data_o,
    output logic [1:0]      enc_mode_o,
    output logic [3:0]      enc_ctl_o,
    output logic            h_sync_o,
    output logic            v_sync_o,
    output logic            locked_o,
    output logic            underflow_o
);

    localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HW          = $clog2(H_TOTAL);
    localparam int unsigned GUARD_START = H_TOTAL - GUARD_LEN;
    localparam int unsigned PRE_START   = H_TOTAL - GUARD_LEN - PREAMBLE_LEN;

    logic [HW-1:0]   h_cnt;
    logic            active, hsync, vsync, next_line_active, frame_start;
    logic            guard_win, pre_win, ready_c, under_d;
    logic [PX_W-1:0] data_d, idle_px;
    logic [3:0]      ctl_d;
    tmds_mode_t      mode_d;
    sched_state_t    state_q, state_d;

    hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .h_cnt            (h_cnt),
        .active           (active),
        .hsync            (hsync),
        .vsync            (vsync),
        .next_line_active (next_line_active),
        .frame_start      (frame_start)
    );

`ifdef HDMI_SCHED_PATTERN_EN
    logic [2:0] bar_idx;

    // Bar index h*8/H_ACTIVE as a count of constant thresholds passed.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < BAR_CNT; k++) begin
            if (h_cnt >= HW'((k * H_ACTIVE + BAR_CNT - 1) / BAR_CNT)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
        idle_px = bar_colour(bar_idx);
    end
`else
    assign idle_px = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Period decode plus frame-lock next state; ready is a same-cycle handshake.
    always_comb begin
        state_d   = state_q;
        mode_d    = MODE_CTRL;
        ctl_d     = '0;
        data_d    = '0;
        ready_c   = 1'b0;
        under_d   = underflow_o;
        guard_win = (h_cnt >= HW'(GUARD_START));
        pre_win   = (h_cnt >= HW'(PRE_START)) && !guard_win;

        if (active) begin
            mode_d = MODE_VIDEO;
        end else if (next_line_active && guard_win) begin
            mode_d = MODE_GUARD;
        end else if (next_line_active && pre_win) begin
            mode_d = MODE_PREAMBLE;
            ctl_d  = CTL_VIDEO_PREAMBLE;
        end

        case (state_q)
            WAIT_SOF: begin
                ready_c = px_valid_i && (!px_sof_i || frame_start);
                if (frame_start && px_valid_i && px_sof_i) begin
                    state_d = RUN;
                    data_d  = px_data_i;
                end else if (active) begin
                    data_d = idle_px;
                end
            end
            RUN: begin
                if (active) begin
                    if (!px_valid_i) begin
                        state_d = WAIT_SOF;
                        under_d = 1'b1;
                    end else if (px_sof_i && !frame_start) begin
                        state_d = WAIT_SOF;
                    end else begin
                        ready_c = 1'b1;
                        data_d  = px_data_i;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    assign px_ready_o = rst_n_i && ready_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enc_data_o  <= '0;
            enc_mode_o  <= MODE_CTRL;
            enc_ctl_o   <= '0;
            h_sync_o    <= ~H_SYNC_POL;
            v_sync_o    <= ~V_SYNC_POL;
            locked_o    <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            enc_data_o  <= data_d;
            enc_mode_o  <= mode_d;
            enc_ctl_o   <= ctl_d;
            h_sync_o    <= hsync ~^ H_SYNC_POL;
            v_sync_o    <= vsync ~^ V_SYNC_POL;
            locked_o    <= (state_d == RUN);
            underflow_o <= under_d;
        end
    end

endmodule

// File: tb/tb_hdmi_period_sched.sv
// Self-checking bench for hdmi_period_sched on a 32x7 raster with a queued expected-output scoreboard.
module tb_hdmi_period_sched;

    localparam int H_ACT = 16, H_TOT = 32, V_ACT = 4, V_TOT = 7;

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  mode;
        logic [3:0]  ctl;
        logic        hs;
        logic        vs;
        logic        locked;
        logic        under;
    } obs_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [23:0] px_data_i;
    logic        px_valid_i, px_sof_i, px_ready_o;
    logic [23:0] enc_data_o;
    logic [1:0]  enc_mode_o;
    logic [3:0]  enc_ctl_o;
    logic        h_sync_o, v_sync_o, locked_o, underflow_o;

    obs_t        exp_q[$];
    int          tests_run = 0, tests_failed = 0;
    int          mh, mv;
    bit          mrun, munder, last_acc;
    int          sp;
    logic [23:0] sdata;

    hdmi_period_sched #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (12),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .px_data_i   (px_data_i),
        .px_valid_i  (px_valid_i),
        .px_sof_i    (px_sof_i),
        .px_ready_o  (px_ready_o),
        .enc_data_o  (enc_data_o),
        .enc_mode_o  (enc_mode_o),
        .enc_ctl_o   (enc_ctl_o),
        .h_sync_o    (h_sync_o),
        .v_sync_o    (v_sync_o),
        .locked_o    (locked_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] idle_pixel(input int h);
`ifdef HDMI_SCHED_PATTERN_EN
        logic [23:0] bars [8] = '{24'hC0C0C0, 24'hC0C000, 24'h00C0C0, 24'h00C000,
                                  24'hC000C0, 24'hC00000, 24'h0000C0, 24'h000000};
        return bars[(h * 8) / H_ACT];
`else
        return (h < 0) ? 24'hFFFFFF : 24'h000000;
`endif
    endfunction

    // Reference model: evaluate one clock at the negedge, queue the outputs due next clock.
    task automatic tick();
        obs_t e;
        bit video, nla, sofpos, rdy, nrun, und;
        @(negedge clk_i);
        video  = (mh < H_ACT) && (mv < V_ACT);
        nla    = (mv == V_TOT - 1) || (mv < V_ACT - 1);
        sofpos = (mh == 0) && (mv == 0);
        e      = '0;
        rdy    = 1'b0;
        nrun   = mrun;
        und    = 1'b0;
        if (video)                       e.mode = 2'd3;
        else if (nla && mh >= H_TOT - 2) e.mode = 2'd2;
        else if (nla && mh >= H_TOT - 10) begin e.mode = 2'd1; e.ctl = 4'b0001; end
        e.hs = (mh >= 18) && (mh < 20);
        e.vs = (mv == 5);
        if (!mrun) begin
            rdy = px_valid_i && (!px_sof_i || sofpos);
            if (sofpos && px_valid_i && px_sof_i) begin
                nrun = 1'b1;
                e.data = px_data_i;
            end else if (video) begin
                e.data = idle_pixel(mh);
            end
        end else if (video) begin
            if (!px_valid_i) begin
                nrun = 1'b0;
                und  = 1'b1;
            end else if (px_sof_i && !sofpos) begin
                nrun = 1'b0;
            end else begin
                rdy = 1'b1;
                e.data = px_data_i;
            end
        end
        tests_run++;
        if (px_ready_o !== rdy) begin
            tests_failed++;
            $display("FAIL ready h=%0d v=%0d: got %b want %b", mh, mv, px_ready_o, rdy);
        end
        last_acc = px_valid_i && px_ready_o;
        munder   = munder | und;
        mrun     = nrun;
        e.locked = nrun;
        e.under  = munder;
        exp_q.push_back(e);
        if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        @(posedge clk_i);
        #2;
    endtask

    always @(posedge clk_i) begin : monitor
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {enc_data_o, enc_mode_o, enc_ctl_o, h_sync_o, v_sync_o, locked_o, underflow_o};
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL outputs @%0t: got data=%h mode=%0d ctl=%h hs=%b vs=%b lk=%b uf=%b want data=%h mode=%0d ctl=%h hs=%b vs=%b lk=%b uf=%b",
                         $time, a.data, a.mode, a.ctl, a.hs, a.vs, a.locked, a.under,
                         e.data, e.mode, e.ctl, e.hs, e.vs, e.locked, e.under);
            end
        end
    end

    task automatic model_reset();
        mh = 0; mv = 0; mrun = 1'b0; munder = 1'b0;
    endtask

    task automatic stream_step();
        px_valid_i = 1'b1;
        px_sof_i   = (sp == 0);
        px_data_i  = sdata;
        tick();
        if (last_acc) begin
            sp    = (sp + 1) % 64;
            sdata = sdata + 24'd1;
        end
    endtask

    task automatic stream_until(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 500) begin
            stream_step();
            n++;
        end
        if (n >= 500) begin
            tests_run++; tests_failed++;
            $display("FAIL timeout reaching h=%0d v=%0d: at h=%0d v=%0d", h, v, mh, mv);
        end
    endtask

    task automatic test_reset();
        obs_t a;
        int hs_cnt = 0, vid_cnt = 0, pre_cnt = 0, grd_cnt = 0, h0, v0;
        rst_n_i = 1'b0; px_valid_i = 1'b0; px_sof_i = 1'b0; px_data_i = '0;
        #1;
        a = {enc_data_o, enc_mode_o, enc_ctl_o, h_sync_o, v_sync_o, locked_o, underflow_o};
        tests_run++;
        if (a !== '0) begin tests_failed++; $display("FAIL reset_values: got %h want 0", a); end
        repeat (3) @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            h0 = mh; v0 = mv;
            tick();
            if (i == 0) begin
                tests_run++;
                if (enc_mode_o !== 2'd3) begin tests_failed++; $display("FAIL first_video: got %0d want 3", enc_mode_o); end
            end
`ifdef HDMI_SCHED_PATTERN_EN
            if (v0 == 0 && (h0 == 0 || h0 == 2 || h0 == 14)) begin
                tests_run++;
                if (enc_data_o !== ((h0 == 0) ? 24'hC0C0C0 : (h0 == 2) ? 24'hC0C000 : 24'h000000)) begin
                    tests_failed++; $display("FAIL pattern h=%0d: got %h", h0, enc_data_o);
                end
            end
`endif
            hs_cnt  += int'(h_sync_o);
            vid_cnt += int'(enc_mode_o == 2'd3);
            pre_cnt += int'(enc_mode_o == 2'd1);
            grd_cnt += int'(enc_mode_o == 2'd2);
        end
        tests_run++;
        if (hs_cnt !== 14) begin tests_failed++; $display("FAIL hsync_count: got %0d want 14", hs_cnt); end
        tests_run++;
        if (vid_cnt !== 64) begin tests_failed++; $display("FAIL video_count: got %0d want 64", vid_cnt); end
        tests_run++;
        if (pre_cnt !== 32) begin tests_failed++; $display("FAIL preamble_count: got %0d want 32", pre_cnt); end
        tests_run++;
        if (grd_cnt !== 8) begin tests_failed++; $display("FAIL guard_count: got %0d want 8", grd_cnt); end
    endtask

    task automatic test_stream();
        int acc = 0;
        sp = 0; sdata = 24'h000100;
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            stream_step();
            acc += int'(last_acc);
            if (i == 0) begin
                tests_run++;
                if (locked_o !== 1'b1) begin tests_failed++; $display("FAIL lock_at_sof: got %b want 1", locked_o); end
            end
        end
        tests_run++;
        if (acc !== 64) begin tests_failed++; $display("FAIL beats_per_frame: got %0d want 64", acc); end
        tests_run++;
        if (underflow_o !== 1'b0) begin tests_failed++; $display("FAIL stream_underflow: got %b want 0", underflow_o); end
    endtask

    task automatic test_underflow();
        logic [23:0] sof_px;
        stream_until(5, 1);
        px_valid_i = 1'b0;
        tick();
        tests_run++;
        if ({enc_data_o, underflow_o, locked_o} !== {24'h0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL underflow_exit: got data=%h uf=%b lk=%b want 000000 1 0", enc_data_o, underflow_o, locked_o);
        end
        stream_until(0, 0);
        tests_run++;
        if (locked_o !== 1'b0) begin tests_failed++; $display("FAIL relock_early: got %b want 0", locked_o); end
        sof_px = sdata;
        stream_step();
        tests_run++;
        if ({locked_o, enc_data_o} !== {1'b1, sof_px}) begin
            tests_failed++; $display("FAIL relock: got lk=%b data=%h want 1 %h", locked_o, enc_data_o, sof_px);
        end
    endtask

    task automatic test_misplaced_sof();
        stream_until(0, 2);
        px_valid_i = 1'b1; px_sof_i = 1'b1; px_data_i = sdata;
        tick();
        tests_run++;
        if (last_acc !== 1'b0) begin tests_failed++; $display("FAIL misplaced_consumed: got %b want 0", last_acc); end
        tests_run++;
        if (locked_o !== 1'b0) begin tests_failed++; $display("FAIL misplaced_unlock: got %b want 0", locked_o); end
        px_valid_i = 1'b0; px_sof_i = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_junk_sof();
        int bad = 0, n = 0;
        for (int i = 0; i < 3; i++) begin
            px_valid_i = 1'b1; px_sof_i = 1'b0; px_data_i = 24'($urandom);
            #1;
            tests_run++;
            if (px_ready_o !== 1'b1) begin tests_failed++; $display("FAIL junk_ready[%0d]: got %b want 1", i, px_ready_o); end
            tick();
        end
        px_valid_i = 1'b1; px_sof_i = 1'b1; px_data_i = 24'hABCDEF;
        while (!(mh == 0 && mv == 0) && n < 500) begin
            #1;
            bad += int'(px_ready_o !== 1'b0);
            tick();
            n++;
        end
        tests_run++;
        if (bad !== 0 || n >= 500) begin tests_failed++; $display("FAIL sof_hold: ready seen %0d times in %0d cycles, want 0", bad, n); end
        tick();
        tests_run++;
        if ({locked_o, enc_data_o} !== {1'b1, 24'hABCDEF}) begin
            tests_failed++; $display("FAIL sof_accept: got lk=%b data=%h want 1 abcdef", locked_o, enc_data_o);
        end
        sp = 1; sdata = 24'hABCDF0;
    endtask

    task automatic test_reset_mid();
        obs_t a;
        stream_until(8, 1);
        rst_n_i = 1'b0;
        #1;
        a = {enc_data_o, enc_mode_o, enc_ctl_o, h_sync_o, v_sync_o, locked_o, underflow_o};
        tests_run++;
        if (a !== '0) begin tests_failed++; $display("FAIL midreset_values: got %h want 0", a); end
        tests_run++;
        if (px_ready_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b want 0", px_ready_o); end
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        rst_n_i = 1'b1; px_valid_i = 1'b0; px_sof_i = 1'b0;
        model_reset();
        tick();
        tests_run++;
        if ({enc_mode_o, locked_o} !== {2'd3, 1'b0}) begin
            tests_failed++; $display("FAIL restart: got mode=%0d lk=%b want 3 0", enc_mode_o, locked_o);
        end
        repeat (40) tick();
        tests_run++;
        if (underflow_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_underflow: got %b want 0", underflow_o); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_underflow();
        test_misplaced_sof();
        test_junk_sof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
